// File: rtl/link_mux_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : link_mux_pkg
// Description : Shared constants, flit type codes and helpers for link_mux.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
package link_mux_pkg;

   // Default bus geometry
   localparam int c_dataw_default = 66;
   localparam int c_vchw_default  = 1;
   localparam int c_portw_default = 4;

   // Generic enable / disable levels
   localparam logic c_enable  = 1'b1;
   localparam logic c_disable = 1'b0;

   // Flit type field, carried in the top three data bits
   typedef enum logic [2:0] {
      FT_NONE = 3'b000,
      FT_HEAD = 3'b001,
      FT_DATA = 3'b010,
      FT_TAIL = 3'b011
   } flit_type_e;

   // Unrecognised codes behave as DATA so they never open or close a packet
   function automatic flit_type_e decode_flit_type(input logic [2:0] code);
      flit_type_e t;
      case (code)
         3'b000:  t = FT_NONE;
         3'b001:  t = FT_HEAD;
         3'b011:  t = FT_TAIL;
         default: t = FT_DATA;
      endcase
      return t;
   endfunction

endpackage
`default_nettype wire

// File: rtl/link_mux_lock.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : link_mux_lock
// Description : Wormhole lock FSM; picks the active source and holds it from
//               a HEAD flit until the matching TAIL flit has been forwarded.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
module link_mux_lock
   import link_mux_pkg::*;
(
   input  logic       clk,
   input  logic       rst_,
   input  logic [1:0] i_sel,
   input  logic [1:0] i_valid,
   input  logic [2:0] i_type_0,
   input  logic [2:0] i_type_1,
   output logic       o_src_en,
   output logic       o_src_idx
);

   localparam logic [0:0] c_st_idle   = 1'b0;
   localparam logic [0:0] c_st_locked = 1'b1;

   logic [0:0] r_state;
   logic [0:0] w_state_nxt;
   logic       r_src;
   logic       w_src_nxt;
   logic       w_src_en;
   logic       w_src_idx;
   logic       w_chosen_valid;
   flit_type_e w_chosen_type;

   assign w_chosen_valid = w_src_en & i_valid[w_src_idx];
   assign w_chosen_type  = decode_flit_type(w_src_idx ? i_type_1 : i_type_0);

   // State register: lock state and latched source index
   always_ff @(posedge clk) begin
      if (!rst_) begin
         r_state <= c_st_idle;
         r_src   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_src   <= w_src_nxt;
      end
   end

   // Next state: open on a valid HEAD, close on a valid TAIL, freeze when invalid
   always_comb begin
      w_state_nxt = r_state;
      w_src_nxt   = r_src;
      case (r_state)
         c_st_idle: begin
            if (w_chosen_valid && (w_chosen_type == FT_HEAD)) begin
               w_state_nxt = c_st_locked;
               w_src_nxt   = w_src_idx;
            end
         end
         c_st_locked: begin
            if (w_chosen_valid && (w_chosen_type == FT_TAIL)) begin
               w_state_nxt = c_st_idle;
            end
         end
         default: begin
            w_state_nxt = c_st_idle;
         end
      endcase
   end

   // Output: latched source while locked, otherwise priority select (input 0 first)
   always_comb begin
      w_src_en  = c_disable;
      w_src_idx = 1'b0;
      if (r_state == c_st_locked) begin
         w_src_en  = c_enable;
         w_src_idx = r_src;
      end else if (i_sel[0]) begin
         w_src_en  = c_enable;
         w_src_idx = 1'b0;
      end else if (i_sel[1]) begin
         w_src_en  = c_enable;
         w_src_idx = 1'b1;
      end
   end

   assign o_src_en  = w_src_en;
   assign o_src_idx = w_src_idx;

endmodule
`default_nettype wire

// File: rtl/link_mux.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : link_mux
// Description : Two-input wormhole flit multiplexer with registered output.
//               A packet that has started on one input owns the output until
//               its TAIL flit, independent of the select bus.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
module link_mux
   import link_mux_pkg::*;
#(
   parameter int DATAW = c_dataw_default,
   parameter int VCHW  = c_vchw_default,
   parameter int PORTW = c_portw_default
) (
   input  logic             clk,
   input  logic             rst_,
   input  logic [DATAW:0]   idata_0,
   input  logic             ivalid_0,
   input  logic [VCHW:0]    ivch_0,
   input  logic [DATAW:0]   idata_1,
   input  logic             ivalid_1,
   input  logic [VCHW:0]    ivch_1,
   input  logic [PORTW:0]   sel,
   output logic [DATAW:0]   odata,
   output logic             ovalid,
   output logic [VCHW:0]    ovch
);

   logic             w_src_en;
   logic             w_src_idx;
   logic [DATAW:0]   w_mux_data;
   logic             w_mux_valid;
   logic [VCHW:0]    w_mux_vch;
   logic [DATAW:0]   r_odata;
   logic             r_ovalid;
   logic [VCHW:0]    r_ovch;

   link_mux_lock u_lock (
      .clk       (clk),
      .rst_      (rst_),
      .i_sel     (sel[1:0]),
      .i_valid   ({ivalid_1, ivalid_0}),
      .i_type_0  (idata_0[DATAW:DATAW-2]),
      .i_type_1  (idata_1[DATAW:DATAW-2]),
      .o_src_en  (w_src_en),
      .o_src_idx (w_src_idx)
   );

   // Upper select bits carry no meaning for a two-input mux
   generate
      if (PORTW >= 2) begin : g_sel_unused
         logic w_unused_sel_hi;
         assign w_unused_sel_hi = ^sel[PORTW:2];
      end
   endgenerate

   assign w_mux_data  = w_src_idx ? idata_1  : idata_0;
   assign w_mux_valid = w_src_idx ? ivalid_1 : ivalid_0;
   assign w_mux_vch   = w_src_idx ? ivch_1   : ivch_0;

   // Output register: zero when no source, hold data/vc on an invalid cycle
   always_ff @(posedge clk) begin
      if (!rst_) begin
         r_odata  <= '0;
         r_ovalid <= c_disable;
         r_ovch   <= '0;
      end else if (!w_src_en) begin
         r_odata  <= '0;
         r_ovalid <= c_disable;
         r_ovch   <= '0;
      end else if (w_mux_valid) begin
         r_odata  <= w_mux_data;
         r_ovalid <= c_enable;
         r_ovch   <= w_mux_vch;
      end else begin
         r_ovalid <= c_disable;
      end
   end

   assign odata  = r_odata;
   assign ovalid = r_ovalid;
   assign ovch   = r_ovch;

endmodule
`default_nettype wire

// File: tb/tb_link_mux.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : tb_link_mux
// Description : Self-checking bench for link_mux: directed packet scenarios
//               plus randomized traffic against a packet-ownership model.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_link_mux;

   localparam logic [2:0] c_head = 3'b001;
   localparam logic [2:0] c_data = 3'b010;
   localparam logic [2:0] c_tail = 3'b011;

   logic        clk;
   logic        rst_;
   logic [66:0] idata_0;
   logic        ivalid_0;
   logic [1:0]  ivch_0;
   logic [66:0] idata_1;
   logic        ivalid_1;
   logic [1:0]  ivch_1;
   logic [4:0]  sel;
   logic [66:0] odata;
   logic        ovalid;
   logic [1:0]  ovch;

   int total;
   int bad;

   // Reference model: which input currently owns the output (-1 = nobody)
   int          owner;
   logic [66:0] m_data;
   logic        m_valid;
   logic [1:0]  m_vch;

   link_mux dut (
      .clk      (clk),
      .rst_     (rst_),
      .idata_0  (idata_0),
      .ivalid_0 (ivalid_0),
      .ivch_0   (ivch_0),
      .idata_1  (idata_1),
      .ivalid_1 (ivalid_1),
      .ivch_1   (ivch_1),
      .sel      (sel),
      .odata    (odata),
      .ovalid   (ovalid),
      .ovch     (ovch)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [66:0] mk(input logic [2:0] t, input logic [63:0] p);
      return {t, p};
   endfunction

   // Advance the model by one clock using the inputs currently applied
   task automatic model_step();
      int          src;
      logic        v;
      logic [66:0] d;
      logic [1:0]  c;
      if (!rst_) begin
         owner = -1; m_data = '0; m_valid = 1'b0; m_vch = '0;
         return;
      end
      if (owner >= 0)  src = owner;
      else if (sel[0]) src = 0;
      else if (sel[1]) src = 1;
      else             src = -1;
      if (src < 0) begin
         m_data = '0; m_valid = 1'b0; m_vch = '0;
         return;
      end
      v = (src == 1) ? ivalid_1 : ivalid_0;
      d = (src == 1) ? idata_1  : idata_0;
      c = (src == 1) ? ivch_1   : ivch_0;
      if (!v) begin
         m_valid = 1'b0;
         return;
      end
      m_data = d; m_valid = 1'b1; m_vch = c;
      if (owner < 0 && d[66:64] == c_head)       owner = src;
      else if (owner >= 0 && d[66:64] == c_tail) owner = -1;
   endtask

   task automatic cyc();
      model_step();
      @(posedge clk);
      #1;
      chk_eq("model_data",  odata,  m_data);
      chk_eq("model_valid", ovalid, m_valid);
      chk_eq("model_vch",   ovch,   m_vch);
   endtask

   task automatic idle_inputs();
      ivalid_0 = 1'b0; ivalid_1 = 1'b0;
      idata_0 = {$urandom, $urandom, $urandom};
      idata_1 = {$urandom, $urandom, $urandom};
   endtask

   initial begin
      logic [66:0] f;
      total = 0; bad = 0; owner = -1;
      m_data = '0; m_valid = 1'b0; m_vch = '0;

      // Reset with active inputs
      rst_ = 1'b0; sel = 5'b00001;
      idata_0 = mk(c_head, 64'h1111); ivalid_0 = 1'b1; ivch_0 = 2'd3;
      idata_1 = mk(c_head, 64'h2222); ivalid_1 = 1'b1; ivch_1 = 2'd2;
      cyc(); cyc();
      chk_eq("rst_odata",  odata,  67'd0);
      chk_eq("rst_ovalid", ovalid, 1'b0);
      chk_eq("rst_ovch",   ovch,   2'd0);
      rst_ = 1'b1;
      idle_inputs(); sel = 5'b00000;
      cyc();

      // Single packet from input 1: HEAD, 20 DATA, TAIL
      sel = 5'b00010; ivch_1 = 2'd1;
      for (int i = 0; i < 22; i++) begin
         if (i == 0)       f = mk(c_head, 64'h4);
         else if (i == 21) f = mk(c_tail, {$urandom, $urandom});
         else              f = mk(c_data, {$urandom, $urandom});
         idata_1 = f; ivalid_1 = 1'b1;
         cyc();
         chk_eq("in1_echo", odata, f);
         chk_eq("in1_valid", ovalid, 1'b1);
      end
      idle_inputs(); cyc();

      // Lock held across a select change
      sel = 5'b00010;
      idata_1 = mk(c_head, 64'hA0); ivalid_1 = 1'b1; cyc();
      idata_1 = mk(c_data, 64'hA1); cyc();
      sel = 5'b00001;
      idata_0 = mk(c_data, 64'hBAD); ivalid_0 = 1'b1; ivch_0 = 2'd0;
      f = mk(c_data, 64'hA2); idata_1 = f; cyc();
      chk_eq("lock_hold", odata, f);
      ivalid_0 = 1'b0;
      idata_1 = mk(c_data, 64'hA3); cyc();
      f = mk(c_tail, 64'hA4); idata_1 = f; cyc();
      chk_eq("lock_tail", odata, f);
      ivalid_1 = 1'b0;
      f = mk(c_head, 64'h55); idata_0 = f; ivalid_0 = 1'b1; cyc();
      chk_eq("switch_head", odata, f);
      idata_0 = mk(c_tail, 64'h56); cyc();
      idle_inputs(); cyc();

      // Both select bits: input 0 wins
      sel = 5'b00011;
      idata_0 = mk(c_head, 64'h9); ivalid_0 = 1'b1;
      idata_1 = mk(c_head, 64'h7); ivalid_1 = 1'b1;
      cyc();
      chk_eq("prio_payload", odata[63:0], 64'h9);
      ivalid_1 = 1'b0;
      idata_0 = mk(c_tail, 64'hA); cyc();
      idle_inputs(); cyc();

      // No source selected
      sel = 5'b00100;
      idata_0 = mk(c_data, 64'h33); ivalid_0 = 1'b1;
      idata_1 = mk(c_data, 64'h44); ivalid_1 = 1'b1;
      cyc();
      chk_eq("nosrc_valid", ovalid, 1'b0);
      chk_eq("nosrc_data",  odata,  67'd0);
      idle_inputs(); cyc();

      // Reset mid-packet drops the lock
      sel = 5'b00010;
      idata_1 = mk(c_head, 64'hC0); ivalid_1 = 1'b1; cyc();
      idata_1 = mk(c_data, 64'hC1); cyc();
      rst_ = 1'b0; cyc();
      chk_eq("midrst_valid", ovalid, 1'b0);
      rst_ = 1'b1; sel = 5'b00001;
      f = mk(c_data, 64'h77); idata_0 = f; ivalid_0 = 1'b1;
      idata_1 = mk(c_data, 64'hC2);
      cyc();
      chk_eq("midrst_idle", odata, f);
      idle_inputs(); sel = 5'b00000; cyc();

      // Walking-ones payload stress, 10 packets with 7-cycle gaps
      sel = 5'b00010;
      for (int p = 0; p < 10; p++) begin
         for (int k = 0; k < 18; k++) begin
            logic [63:0] pl;
            pl = (k == 0 || k == 1) ? 64'd0 : (64'd1 << ((k - 2 + p * 7) % 64));
            if (k == 0)       f = mk(c_head, pl);
            else if (k == 17) f = mk(c_tail, pl);
            else              f = mk(c_data, pl);
            idata_1 = f; ivalid_1 = 1'b1; ivch_1 = p[1:0];
            cyc();
            chk_eq("walk_echo", odata, f);
         end
         for (int g = 0; g < 7; g++) begin
            ivalid_1 = 1'b0;
            cyc();
            chk_eq("walk_gap_valid", ovalid, 1'b0);
         end
      end

      // Randomized traffic
      for (int i = 0; i < 800; i++) begin
         rst_     = ($urandom_range(0, 63) != 0);
         sel      = 5'($urandom);
         ivalid_0 = ($urandom_range(0, 3) != 0);
         ivalid_1 = ($urandom_range(0, 3) != 0);
         ivch_0   = 2'($urandom);
         ivch_1   = 2'($urandom);
         idata_0  = mk(3'($urandom_range(0, 7)), {$urandom, $urandom});
         idata_1  = mk(3'($urandom_range(0, 7)), {$urandom, $urandom});
         cyc();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
